sram_fifo_ctrl_2ch: RTL and testbench

Two-channel FIFO controller that sits directly upstream of the 4-port 8-bit SRAM and drives all four of its ports. Each channel uses one write port and one read port of the SRAM. The address space is split into two halves, one per channel. Producers and consumers see a valid/ready push interface and a request/valid pop interface; the SRAM provides the storage.

---
 rtl/sram_fifo_ctrl_2ch.sv | 158 +++++++++++++++
 tb/tb_sram_fifo_ctrl_2ch.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_fifo_ctrl_2ch.sv
// sram_fifo_ctrl_2ch
// Two independent FIFOs sharing one 4-port SRAM. Channel 0 uses write port A
// and read port C in the lower half of the address space. Channel 1 uses
// write port B and read port D in the upper half.
// Optional build macro SRAM_FIFO_ERR_FLAG_EN adds a sticky per-channel error
// flag (push while full / pop while empty), cleared only by reset.
module sram_fifo_ctrl_2ch #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  Clk_In,
  input  logic                  Reset_In,
  input  logic                  Push_0_Valid_In,
  input  logic [DATA_WIDTH-1:0] Push_0_Data_In,
  output logic                  Push_0_Ready_Out,
  input  logic                  Push_1_Valid_In,
  input  logic [DATA_WIDTH-1:0] Push_1_Data_In,
  output logic                  Push_1_Ready_Out,
  input  logic                  Pop_0_Req_In,
  output logic                  Pop_0_Valid_Out,
  output logic [DATA_WIDTH-1:0] Pop_0_Data_Out,
  input  logic                  Pop_1_Req_In,
  output logic                  Pop_1_Valid_Out,
  output logic [DATA_WIDTH-1:0] Pop_1_Data_Out,
  output logic [ADDR_WIDTH-1:0] Count_0_Out,
  output logic [ADDR_WIDTH-1:0] Count_1_Out,
  output logic [DATA_WIDTH-1:0] Port_W_A_Data_Out,
  output logic [ADDR_WIDTH-1:0] Port_W_A_Address_Out,
  output logic                  Port_W_A_Write_Enable_Out,
  output logic [DATA_WIDTH-1:0] Port_W_B_Data_Out,
  output logic [ADDR_WIDTH-1:0] Port_W_B_Address_Out,
  output logic                  Port_W_B_Write_Enable_Out,
  output logic [ADDR_WIDTH-1:0] Port_R_C_Address_Out,
  output logic                  Port_R_C_Read_Enable_Out,
  input  logic [DATA_WIDTH-1:0] Port_R_C_Data_In,
  output logic [ADDR_WIDTH-1:0] Port_R_D_Address_Out,
  output logic                  Port_R_D_Read_Enable_Out,
`ifdef SRAM_FIFO_ERR_FLAG_EN
  output logic                  Err_0_Out,
  output logic                  Err_1_Out,
`endif
  input  logic [DATA_WIDTH-1:0] Port_R_D_Data_In
);

  localparam int PW       = ADDR_WIDTH - 1;
  localparam int CH_DEPTH = 2 ** PW;
  localparam logic [ADDR_WIDTH-1:0] DEPTH_C = ADDR_WIDTH'(CH_DEPTH);

  // Per-channel state, index 0/1 is the channel number (and the address MSB)
  logic [1:0][PW-1:0]         wr_ptr;
  logic [1:0][PW-1:0]         rd_ptr;
  logic [1:0][ADDR_WIDTH-1:0] count;
  logic [1:0]                 pop_pending;

  logic [1:0]                 push_valid;
  logic [1:0]                 pop_req;
  logic [1:0][DATA_WIDTH-1:0] push_data;
  logic [1:0]                 full;
  logic [1:0]                 empty;
  logic [1:0]                 push_ready;
  logic [1:0]                 push_acc;
  logic [1:0]                 pop_acc;
  logic [1:0][ADDR_WIDTH-1:0] wr_addr;
  logic [1:0][DATA_WIDTH-1:0] wr_data;
  logic [1:0][ADDR_WIDTH-1:0] rd_addr;

  assign push_valid = {Push_1_Valid_In, Push_0_Valid_In};
  assign pop_req    = {Pop_1_Req_In, Pop_0_Req_In};
  assign push_data  = {Push_1_Data_In, Push_0_Data_In};

  // Handshake decode from registered occupancy; reset blocks all SRAM accesses
  always_comb begin
    full       = '0;
    empty      = '0;
    push_ready = '0;
    push_acc   = '0;
    pop_acc    = '0;
    wr_addr    = '0;
    wr_data    = '0;
    rd_addr    = '0;
    for (int c = 0; c < 2; c++) begin
      full[c]       = (count[c] == DEPTH_C);
      empty[c]      = (count[c] == '0);
      push_ready[c] = !full[c] && !Reset_In;
      push_acc[c]   = push_valid[c] && push_ready[c];
      pop_acc[c]    = pop_req[c] && !empty[c] && !Reset_In;
      if (push_acc[c]) begin
        wr_addr[c] = {1'(c), wr_ptr[c]};
        wr_data[c] = push_data[c];
      end
      if (pop_acc[c]) begin
        rd_addr[c] = {1'(c), rd_ptr[c]};
      end
    end
  end

  // Pointer, occupancy and pop-pending update; pointers wrap naturally at CH_DEPTH
  always_ff @(posedge Clk_In) begin
    if (Reset_In) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      pop_pending <= '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (push_acc[c]) wr_ptr[c] <= wr_ptr[c] + 1'b1;
        if (pop_acc[c])  rd_ptr[c] <= rd_ptr[c] + 1'b1;
        pop_pending[c] <= pop_acc[c];
        case ({push_acc[c], pop_acc[c]})
          2'b10:   count[c] <= count[c] + 1'b1;
          2'b01:   count[c] <= count[c] - 1'b1;
          default: count[c] <= count[c];
        endcase
      end
    end
  end

`ifdef SRAM_FIFO_ERR_FLAG_EN
  logic [1:0] err;

  // Sticky misuse flag: push attempted while full or pop attempted while empty
  always_ff @(posedge Clk_In) begin
    if (Reset_In) begin
      err <= '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        if ((push_valid[c] && full[c]) || (pop_req[c] && empty[c])) err[c] <= 1'b1;
      end
    end
  end

  assign Err_0_Out = err[0];
  assign Err_1_Out = err[1];
`endif

  assign Push_0_Ready_Out = push_ready[0];
  assign Push_1_Ready_Out = push_ready[1];
  assign Count_0_Out      = count[0];
  assign Count_1_Out      = count[1];

  // Read data comes straight from the SRAM one cycle after the read enable
  assign Pop_0_Valid_Out  = pop_pending[0];
  assign Pop_1_Valid_Out  = pop_pending[1];
  assign Pop_0_Data_Out   = Port_R_C_Data_In;
  assign Pop_1_Data_Out   = Port_R_D_Data_In;

  assign Port_W_A_Write_Enable_Out = push_acc[0];
  assign Port_W_A_Address_Out      = wr_addr[0];
  assign Port_W_A_Data_Out         = wr_data[0];
  assign Port_W_B_Write_Enable_Out = push_acc[1];
  assign Port_W_B_Address_Out      = wr_addr[1];
  assign Port_W_B_Data_Out         = wr_data[1];
  assign Port_R_C_Read_Enable_Out  = pop_acc[0];
  assign Port_R_C_Address_Out      = rd_addr[0];
  assign Port_R_D_Read_Enable_Out  = pop_acc[1];
  assign Port_R_D_Address_Out      = rd_addr[1];

endmodule

// File: tb/tb_sram_fifo_ctrl_2ch.sv
// Testbench for sram_fifo_ctrl_2ch with a behavioural 4-port SRAM model.
module tb_sram_fifo_ctrl_2ch;

  logic       clk = 1'b0;
  logic       rst;
  logic       p0v, p1v, r0, r1;
  logic [7:0] p0d, p1d;
  logic       rdy0, rdy1, v0, v1;
  logic [7:0] d0, d1, cnt0, cnt1;
  logic [7:0] wa_data, wa_addr, wb_data, wb_addr, rc_addr, rd_addr;
  logic       wa_we, wb_we, rc_re, rd_re;
  logic [7:0] rc_data = 8'h00;
  logic [7:0] rd_data = 8'h00;
`ifdef SRAM_FIFO_ERR_FLAG_EN
  logic       err0, err1;
`endif

  logic [7:0] mem [256];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sram_fifo_ctrl_2ch dut (
    .Clk_In                    (clk),
    .Reset_In                  (rst),
    .Push_0_Valid_In           (p0v),
    .Push_0_Data_In            (p0d),
    .Push_0_Ready_Out          (rdy0),
    .Push_1_Valid_In           (p1v),
    .Push_1_Data_In            (p1d),
    .Push_1_Ready_Out          (rdy1),
    .Pop_0_Req_In              (r0),
    .Pop_0_Valid_Out           (v0),
    .Pop_0_Data_Out            (d0),
    .Pop_1_Req_In              (r1),
    .Pop_1_Valid_Out           (v1),
    .Pop_1_Data_Out            (d1),
    .Count_0_Out               (cnt0),
    .Count_1_Out               (cnt1),
    .Port_W_A_Data_Out         (wa_data),
    .Port_W_A_Address_Out      (wa_addr),
    .Port_W_A_Write_Enable_Out (wa_we),
    .Port_W_B_Data_Out         (wb_data),
    .Port_W_B_Address_Out      (wb_addr),
    .Port_W_B_Write_Enable_Out (wb_we),
    .Port_R_C_Address_Out      (rc_addr),
    .Port_R_C_Read_Enable_Out  (rc_re),
    .Port_R_C_Data_In          (rc_data),
    .Port_R_D_Address_Out      (rd_addr),
    .Port_R_D_Read_Enable_Out  (rd_re),
`ifdef SRAM_FIFO_ERR_FLAG_EN
    .Err_0_Out                 (err0),
    .Err_1_Out                 (err1),
`endif
    .Port_R_D_Data_In          (rd_data)
  );

  // SRAM model: write at the edge, registered read data one cycle later
  always @(posedge clk) begin
    if (wa_we) mem[wa_addr] <= wa_data;
    if (wb_we) mem[wb_addr] <= wb_data;
    if (rc_re) rc_data <= mem[rc_addr];
    if (rd_re) rd_data <= mem[rd_addr];
  end

  typedef struct packed {
    logic       rst, p0v; logic [7:0] p0d; logic p1v; logic [7:0] p1d; logic r0, r1;
    logic       wa_we; logic [7:0] wa_addr, wa_data;
    logic       wb_we; logic [7:0] wb_addr, wb_data;
    logic       rc_re; logic [7:0] rc_addr;
    logic       rd_re; logic [7:0] rd_addr;
    logic       rdy0, rdy1;
    logic [7:0] cnt0, cnt1;
    logic       v0; logic [7:0] d0;
    logic       v1; logic [7:0] d1;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic a, input logic [7:0] ad,
                       input logic b, input logic [7:0] bd, input logic q0, input logic q1);
    rst = r; p0v = a; p0d = ad; p1v = b; p1d = bd; r0 = q0; r1 = q1;
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic to_post();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int i, input vec_t v);
    drive(v.rst, v.p0v, v.p0d, v.p1v, v.p1d, v.r0, v.r1);
    to_neg();
    chk($sformatf("v%0d wa_we", i), 32'(wa_we), 32'(v.wa_we));
    chk($sformatf("v%0d wa_addr", i), 32'(wa_addr), 32'(v.wa_addr));
    chk($sformatf("v%0d wa_data", i), 32'(wa_data), 32'(v.wa_data));
    chk($sformatf("v%0d wb_we", i), 32'(wb_we), 32'(v.wb_we));
    chk($sformatf("v%0d wb_addr", i), 32'(wb_addr), 32'(v.wb_addr));
    chk($sformatf("v%0d wb_data", i), 32'(wb_data), 32'(v.wb_data));
    chk($sformatf("v%0d rc_re", i), 32'(rc_re), 32'(v.rc_re));
    chk($sformatf("v%0d rc_addr", i), 32'(rc_addr), 32'(v.rc_addr));
    chk($sformatf("v%0d rd_re", i), 32'(rd_re), 32'(v.rd_re));
    chk($sformatf("v%0d rd_addr", i), 32'(rd_addr), 32'(v.rd_addr));
    chk($sformatf("v%0d ready0", i), 32'(rdy0), 32'(v.rdy0));
    chk($sformatf("v%0d ready1", i), 32'(rdy1), 32'(v.rdy1));
    to_post();
    chk($sformatf("v%0d count0", i), 32'(cnt0), 32'(v.cnt0));
    chk($sformatf("v%0d count1", i), 32'(cnt1), 32'(v.cnt1));
    chk($sformatf("v%0d pop0_valid", i), 32'(v0), 32'(v.v0));
    chk($sformatf("v%0d pop1_valid", i), 32'(v1), 32'(v.v1));
    if (v.v0) chk($sformatf("v%0d pop0_data", i), 32'(d0), 32'(v.d0));
    if (v.v1) chk($sformatf("v%0d pop1_data", i), 32'(d1), 32'(v.d1));
  endtask

  function automatic vec_t nv(input logic [7:0] c0, input logic [7:0] c1);
    vec_t v;
    v = '0;
    v.rdy0 = 1'b1; v.rdy1 = 1'b1;
    v.cnt0 = c0;   v.cnt1 = c1;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    drive(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    @(posedge clk); #1;

    // ---------------- table-driven vectors ----------------
    v = nv(0, 0); v.rst = 1; v.rdy0 = 0; v.rdy1 = 0; vecs.push_back(v);
    v = nv(1, 0); v.p0v = 1; v.p0d = 8'h11; v.wa_we = 1; v.wa_addr = 8'h00; v.wa_data = 8'h11; vecs.push_back(v);
    v = nv(2, 0); v.p0v = 1; v.p0d = 8'h22; v.wa_we = 1; v.wa_addr = 8'h01; v.wa_data = 8'h22; vecs.push_back(v);
    v = nv(3, 0); v.p0v = 1; v.p0d = 8'h33; v.wa_we = 1; v.wa_addr = 8'h02; v.wa_data = 8'h33; vecs.push_back(v);
    v = nv(3, 1); v.p1v = 1; v.p1d = 8'hA5; v.wb_we = 1; v.wb_addr = 8'h80; v.wb_data = 8'hA5; vecs.push_back(v);
    v = nv(3, 0); v.r1 = 1; v.rd_re = 1; v.rd_addr = 8'h80; v.v1 = 1; v.d1 = 8'hA5; vecs.push_back(v);
    v = nv(3, 0); vecs.push_back(v);
    v = nv(2, 1); v.r0 = 1; v.rc_re = 1; v.rc_addr = 8'h00; v.p1v = 1; v.p1d = 8'h5B;
    v.wb_we = 1; v.wb_addr = 8'h81; v.wb_data = 8'h5B; v.v0 = 1; v.d0 = 8'h11; vecs.push_back(v);
    v = nv(1, 0); v.r0 = 1; v.r1 = 1; v.rc_re = 1; v.rc_addr = 8'h01; v.rd_re = 1; v.rd_addr = 8'h81;
    v.v0 = 1; v.d0 = 8'h22; v.v1 = 1; v.d1 = 8'h5B; vecs.push_back(v);
    v = nv(2, 0); v.p0v = 1; v.p0d = 8'h44; v.r1 = 1; v.wa_we = 1; v.wa_addr = 8'h03; v.wa_data = 8'h44; vecs.push_back(v);
    v = nv(2, 0); v.p0v = 1; v.p0d = 8'h55; v.r0 = 1; v.wa_we = 1; v.wa_addr = 8'h04; v.wa_data = 8'h55;
    v.rc_re = 1; v.rc_addr = 8'h02; v.v0 = 1; v.d0 = 8'h33; vecs.push_back(v);
    v = nv(1, 1); v.r0 = 1; v.rc_re = 1; v.rc_addr = 8'h03; v.p1v = 1; v.p1d = 8'h66;
    v.wb_we = 1; v.wb_addr = 8'h82; v.wb_data = 8'h66; v.v0 = 1; v.d0 = 8'h44; vecs.push_back(v);

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // ---------------- fill ch0, overflow, pop+push when full ----------------
    drive(1, 0, 0, 0, 0, 0, 0); to_post();
    for (int i = 0; i < 128; i++) begin
      drive(0, 1, 8'(i), 0, 0, 0, 0);
      to_neg();
      chk($sformatf("fill%0d we", i), 32'(wa_we), 32'd1);
      chk($sformatf("fill%0d addr", i), 32'(wa_addr), 32'(i));
      to_post();
    end
    chk("full count0", 32'(cnt0), 32'd128);
    chk("full ready0", 32'(rdy0), 32'd0);
    drive(0, 1, 8'hEE, 0, 0, 0, 0);
    to_neg();
    chk("overflow we", 32'(wa_we), 32'd0);
    to_post();
    chk("overflow count0", 32'(cnt0), 32'd128);
`ifdef SRAM_FIFO_ERR_FLAG_EN
    chk("overflow err0", 32'(err0), 32'd1);
    chk("overflow err1", 32'(err1), 32'd0);
`endif
    drive(0, 1, 8'hEF, 0, 0, 1, 0);
    to_neg();
    chk("full pp we", 32'(wa_we), 32'd0);
    chk("full pp re", 32'(rc_re), 32'd1);
    chk("full pp raddr", 32'(rc_addr), 32'h00);
    to_post();
    chk("full pp count0", 32'(cnt0), 32'd127);
    chk("full pp valid", 32'(v0), 32'd1);
    chk("full pp data", 32'(d0), 32'h00);
    chk("full pp ready0", 32'(rdy0), 32'd1);

    // ---------------- ch1 wrap-around ----------------
    drive(1, 0, 0, 0, 0, 0, 0); to_post();
    for (int i = 0; i < 200; i++) begin
      drive(0, 0, 0, 1, 8'(i), 0, 0);
      to_neg();
      chk($sformatf("wrap%0d waddr", i), 32'({wb_we, wb_addr}), 32'({1'b1, 8'h80 | 8'(i % 128)}));
      to_post();
      drive(0, 0, 0, 0, 0, 0, 1);
      to_neg();
      chk($sformatf("wrap%0d raddr", i), 32'({rd_re, rd_addr}), 32'({1'b1, 8'h80 | 8'(i % 128)}));
      to_post();
      chk($sformatf("wrap%0d pop", i), 32'({v1, d1, cnt1}), 32'({1'b1, 8'(i), 8'd0}));
    end

    // ---------------- empty ch0 with simultaneous push and pop ----------------
    drive(1, 0, 0, 0, 0, 0, 0); to_post();
    drive(0, 1, 8'h5A, 0, 0, 1, 0);
    to_neg();
    chk("empty pp we", 32'({wa_we, wa_addr, wa_data}), 32'({1'b1, 8'h00, 8'h5A}));
    chk("empty pp re", 32'(rc_re), 32'd0);
    to_post();
    chk("empty pp valid", 32'(v0), 32'd0);
    chk("empty pp count0", 32'(cnt0), 32'd1);
`ifdef SRAM_FIFO_ERR_FLAG_EN
    chk("empty pp err0", 32'(err0), 32'd1);
`endif
    drive(0, 0, 0, 0, 0, 1, 0);
    to_neg();
    chk("empty pop re", 32'({rc_re, rc_addr}), 32'({1'b1, 8'h00}));
    to_post();
    chk("empty pop data", 32'({v0, d0, cnt0}), 32'({1'b1, 8'h5A, 8'd0}));

    // ---------------- reset with a pop in flight ----------------
    drive(1, 0, 0, 0, 0, 0, 0); to_post();
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, 8'(8'hC0 + i), 1, 8'(8'hD0 + i), 0, 0);
      to_post();
    end
    drive(0, 0, 0, 0, 0, 1, 0);
    to_post();
    chk("inflight count0", 32'(cnt0), 32'd5);
    chk("inflight valid", 32'({v0, d0}), 32'({1'b1, 8'hC0}));
    drive(1, 0, 0, 0, 0, 1, 1);
    to_neg();
    chk("rst re", 32'({rc_re, rd_re}), 32'd0);
    chk("rst ready", 32'({rdy0, rdy1}), 32'd0);
    to_post();
    chk("rst valid", 32'({v0, v1}), 32'd0);
    chk("rst counts", 32'({cnt0, cnt1}), 32'd0);
`ifdef SRAM_FIFO_ERR_FLAG_EN
    chk("rst err", 32'({err0, err1}), 32'd0);
`endif
    drive(0, 1, 8'h77, 1, 8'h88, 0, 0);
    to_neg();
    chk("rst wa", 32'({wa_we, wa_addr}), 32'({1'b1, 8'h00}));
    chk("rst wb", 32'({wb_we, wb_addr}), 32'({1'b1, 8'h80}));
    to_post();
    drive(0, 0, 0, 0, 0, 1, 1);
    to_neg();
    chk("rst rc", 32'({rc_re, rc_addr}), 32'({1'b1, 8'h00}));
    chk("rst rd", 32'({rd_re, rd_addr}), 32'({1'b1, 8'h80}));
    to_post();
    chk("rst pop data", 32'({v0, d0, v1, d1}), 32'({1'b1, 8'h77, 1'b1, 8'h88}));

    drive(0, 0, 0, 0, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
